// File: rtl/random_word_packer.sv
// random_word_packer: XOR-reduces NUM_CH entropy channels to one bit per strobe,
// optionally applies von Neumann debiasing, packs accepted bits MSB-first into
// WORD_W-bit words and hands each word to a UART over a valid/ready handshake.
// Words are produced in bursts of BURST_LEN (debounced button) or continuously.

// One parity stage per entropy channel; the stages chain into an XOR reduction.
module rwp_lane (
  input  logic par_in,
  input  logic raw,
  output logic par_out
);
  assign par_out = par_in ^ raw;
endmodule

module random_word_packer #(
  parameter int NUM_CH        = 8,
  parameter int WORD_W        = 8,
  parameter int DEBOUNCE_TIME = 5,
  parameter int BURST_LEN     = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_CH-1:0]              raw_Bit,
  input  logic                           bit_Strobe,
  input  logic                           button_Trig,
  input  logic                           mode_Cont,
  input  logic                           debias_En,
  input  logic                           tx_Done,
  output logic [WORD_W-1:0]              random_Word,
  output logic                           valid_Sig,
  output logic                           busy,
  output logic [$clog2(BURST_LEN+1)-1:0] words_Left
);

  localparam int DW = $clog2(DEBOUNCE_TIME);
  localparam int BW = $clog2(WORD_W);
  localparam int LW = $clog2(BURST_LEN+1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FILL = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]        state;
  logic [DW-1:0]     deb_count;
  logic              en, en_q, press;
  logic [NUM_CH:0]   par_chain;
  logic              par;
  logic              pair_flag, pair_bit;
  logic              acc_vld, acc_bit;
  logic [WORD_W-1:0] shreg, next_word;
  logic [BW-1:0]     bit_cnt;
  logic [LW-1:0]     left_dec;

  // Parity reduction across all channels as an array of lane stages
  assign par_chain[0] = 1'b0;
  rwp_lane u_lane [NUM_CH-1:0] (
    .par_in  (par_chain[NUM_CH-1:0]),
    .raw     (raw_Bit),
    .par_out (par_chain[NUM_CH:1])
  );
  assign par = par_chain[NUM_CH];

  // The press is qualified by the button still being high, so the
  // DEBOUNCE_TIME-th consecutive high cycle is the one that fires it.
  assign en    = (deb_count == DW'(DEBOUNCE_TIME-1));
  assign press = en & ~en_q & button_Trig;
  assign busy  = (state != IDLE);

  // Debounce counter, saturating while the button is held
  always_ff @(posedge clk) begin
    if (!reset) begin
      deb_count <= '0;
      en_q      <= 1'b0;
    end else begin
      en_q <= en;
      if (!button_Trig)
        deb_count <= '0;
      else if (!en)
        deb_count <= deb_count + DW'(1);
    end
  end

  // Accepted-bit selection: raw parity, or the first bit of an unequal pair
  always_comb begin
    acc_vld = 1'b0;
    acc_bit = par;
    if (state == FILL && bit_Strobe) begin
      if (!debias_En) begin
        acc_vld = 1'b1;
      end else if (pair_flag && (par != pair_bit)) begin
        acc_vld = 1'b1;
        acc_bit = pair_bit;
      end
    end
  end

  assign next_word = {shreg[WORD_W-2:0], acc_bit};
  assign left_dec  = words_Left - LW'(1);

  // Control FSM with packing and output word registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      shreg       <= '0;
      bit_cnt     <= '0;
      pair_flag   <= 1'b0;
      pair_bit    <= 1'b0;
      random_Word <= '0;
      valid_Sig   <= 1'b0;
      words_Left  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (press || mode_Cont) begin
            words_Left <= LW'(BURST_LEN);
            bit_cnt    <= '0;
            pair_flag  <= 1'b0;
            state      <= FILL;
          end
        end
        FILL: begin
          if (bit_Strobe && debias_En) begin
            pair_flag <= ~pair_flag;
            if (!pair_flag)
              pair_bit <= par;
          end
          if (acc_vld) begin
            shreg <= next_word;
            if (bit_cnt == BW'(WORD_W-1)) begin
              random_Word <= next_word;
              valid_Sig   <= 1'b1;
              bit_cnt     <= '0;
              state       <= HOLD;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
            end
          end
        end
        HOLD: begin
          // Strobes are dropped here; only the handshake moves us on
          if (tx_Done) begin
            valid_Sig   <= 1'b0;
            random_Word <= '0;
            pair_flag   <= 1'b0;
            if (left_dec != '0) begin
              words_Left <= left_dec;
              state      <= FILL;
            end else if (mode_Cont) begin
              words_Left <= LW'(BURST_LEN);
              state      <= FILL;
            end else begin
              words_Left <= '0;
              state      <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
      // Leaving debias mode abandons any half-collected pair
      if (!debias_En)
        pair_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_random_word_packer.sv
// Bench for random_word_packer: directed scenarios plus a randomized phase,
// every cycle compared against a behavioural model of the word stream.
module tb_random_word_packer;

  localparam int NUM_CH = 8;
  localparam int WORD_W = 8;
  localparam int DEB    = 5;
  localparam int BL     = 2;

  logic              clk;
  logic              rst;
  logic [NUM_CH-1:0] raw;
  logic              stb, btn, cont, deb, tx;
  logic [WORD_W-1:0] random_Word;
  logic              valid_Sig, busy;
  logic [1:0]        words_Left;

  int n_vec = 0;
  int n_err = 0;

  // Model state
  bit m_busy, m_valid, m_pair, m_pbit;
  int m_word, m_sh, m_n, m_left, m_run;

  random_word_packer #(
    .NUM_CH(NUM_CH), .WORD_W(WORD_W), .DEBOUNCE_TIME(DEB), .BURST_LEN(BL)
  ) dut (
    .clk(clk), .reset(rst), .raw_Bit(raw), .bit_Strobe(stb),
    .button_Trig(btn), .mode_Cont(cont), .debias_En(deb), .tx_Done(tx),
    .random_Word(random_Word), .valid_Sig(valid_Sig), .busy(busy),
    .words_Left(words_Left)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Random channel bits whose XOR equals b
  function automatic logic [NUM_CH-1:0] par_raw(input bit b);
    logic [NUM_CH-1:0] r;
    r = NUM_CH'($urandom);
    if ((^r) != b) r[0] = ~r[0];
    return r;
  endfunction

  // Behavioural model of one clock edge, from the inputs seen at that edge
  task automatic model_edge();
    bit p, press, have, b;
    p = ^raw;
    if (!rst) begin
      m_busy = 0; m_valid = 0; m_pair = 0; m_pbit = 0;
      m_word = 0; m_sh = 0; m_n = 0; m_left = 0; m_run = 0;
      return;
    end
    m_run = btn ? m_run + 1 : 0;
    press = (m_run == DEB);
    if (!m_busy) begin
      if (press || cont) begin
        m_busy = 1; m_left = BL; m_n = 0; m_pair = 0;
      end
    end else if (!m_valid) begin
      if (stb) begin
        have = 0; b = p;
        if (!deb) have = 1;
        else if (!m_pair) begin m_pair = 1; m_pbit = p; end
        else begin
          m_pair = 0;
          if (p != m_pbit) begin have = 1; b = m_pbit; end
        end
        if (have) begin
          m_sh = ((m_sh * 2) + int'(b)) % (1 << WORD_W);
          m_n++;
          if (m_n == WORD_W) begin m_word = m_sh; m_valid = 1; m_n = 0; end
        end
      end
    end else if (tx) begin
      m_valid = 0; m_word = 0; m_pair = 0; m_left--;
      if (m_left == 0) begin
        if (cont) m_left = BL;
        else m_busy = 0;
      end
    end
    if (!deb) m_pair = 0;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("m_word",  random_Word, m_word);
    chk("m_valid", valid_Sig,   m_valid);
    chk("m_busy",  busy,        m_busy);
    chk("m_left",  words_Left,  m_left);
  endtask

  // Strobe random bits until a word is held, bounded
  task automatic fill_word();
    stb = 1;
    for (int i = 0; i < 64 && !valid_Sig; i++) begin
      raw = NUM_CH'($urandom);
      step();
    end
    stb = 0;
    chk("fill_done", valid_Sig, 1);
  endtask

  task automatic push_bits(input logic [7:0] pat);
    stb = 1;
    for (int i = 7; i >= 0; i--) begin
      raw = par_raw(pat[i]);
      step();
      if (i == 1) chk("pre_valid", valid_Sig, 0);
    end
    stb = 0;
  endtask

  initial begin
    logic [7:0] dpat;
    int hold_cnt;
    m_busy = 0; m_valid = 0; m_pair = 0; m_pbit = 0;
    m_word = 0; m_sh = 0; m_n = 0; m_left = 0; m_run = 0;
    rst = 0; raw = '0; stb = 1; btn = 1; cont = 0; deb = 0; tx = 0;

    // Reset with button and strobes active
    repeat (3) begin raw = NUM_CH'($urandom); step(); end
    chk("rst_word", random_Word, 0);
    chk("rst_valid", valid_Sig, 0);
    chk("rst_busy", busy, 0);
    chk("rst_left", words_Left, 0);
    rst = 1; btn = 0; stb = 0;
    repeat (2) step();

    // Too-short press
    btn = 1; repeat (4) step();
    btn = 0; repeat (3) step();
    chk("short_press", busy, 0);

    // Valid press, then held long
    btn = 1; repeat (4) step();
    chk("pre_press", busy, 0);
    step();
    chk("press_busy", busy, 1);
    chk("press_left", words_Left, 2);
    repeat (95) step();
    btn = 0; step();
    chk("one_burst", words_Left, 2);

    // Packing without debias
    push_bits(8'hB2);
    chk("b2_valid", valid_Sig, 1);
    chk("b2_word", random_Word, 8'hB2);
    stb = 1;
    repeat (10) begin raw = NUM_CH'($urandom); step(); chk("b2_hold", random_Word, 8'hB2); end
    stb = 0; tx = 1; step(); tx = 0;
    chk("xfer1_valid", valid_Sig, 0);
    chk("xfer1_left", words_Left, 1);
    chk("xfer1_busy", busy, 1);

    // Debias: pairs (0,1),(1,1),(1,0),(0,0) repeated
    deb = 1; stb = 1; dpat = 8'b01111000;
    repeat (4) begin
      for (int i = 7; i >= 0; i--) begin raw = par_raw(dpat[i]); step(); end
    end
    stb = 0;
    chk("deb_valid", valid_Sig, 1);
    chk("deb_word", random_Word, 8'h55);
    tx = 1; step(); tx = 0;
    chk("burst_end_busy", busy, 0);
    chk("burst_end_left", words_Left, 0);

    // Continuous mode
    deb = 0; cont = 1; step();
    chk("cont_busy", busy, 1);
    chk("cont_left", words_Left, 2);
    fill_word(); tx = 1; step(); tx = 0;
    chk("cont_left1", words_Left, 1);
    fill_word(); tx = 1; step(); tx = 0;
    chk("cont_reload", words_Left, 2);
    chk("cont_busy2", busy, 1);

    // Reset while holding a word
    cont = 0;
    fill_word();
    rst = 0; step();
    chk("midrst_valid", valid_Sig, 0);
    chk("midrst_word", random_Word, 0);
    chk("midrst_busy", busy, 0);
    rst = 1; step();
    btn = 1; repeat (5) step(); btn = 0;
    chk("repress_busy", busy, 1);
    push_bits(8'h3C);
    chk("fresh_word", random_Word, 8'h3C);
    tx = 1; step(); tx = 0;

    // Randomized phase
    hold_cnt = 0;
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 399) != 0);
      stb = ($urandom_range(0, 3) != 0);
      raw = NUM_CH'($urandom);
      tx  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 49) == 0) deb = ~deb;
      if ($urandom_range(0, 149) == 0) cont = ~cont;
      if (hold_cnt > 0) begin btn = 1; hold_cnt--; end
      else begin
        btn = 0;
        if ($urandom_range(0, 29) == 0) hold_cnt = $urandom_range(1, 12);
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
